spi_slave_word_rx: RTL
======================

SPI_SLAVE_WORD_RX -- requirements
Module: spi_slave_word_rx

Interface
REQ-001 Parameters SHALL be:
- WORD_BITS, default 16: bits per frame.
- SYNC_STAGES, default 2: synchronizer depth on each SPI input.
REQ-002 Ports SHALL be:
- i_Clk  in  1  system clock (CLOCK_50 domain); the block's only clock.
- i_Rst  in  1  reset; synchronous, active-high.
- i_SPI_Clk  in  1  asynchronous SPI clock, mode 0 (CPOL=0, CPHA=0).
- i_SPI_MOSI  in  1  asynchronous serial data in, MSB first.
- i_SPI_CS_n  in  1  asynchronous active-low frame select.
- o_SPI_MISO  out  1  serial data out, MSB first.
- i_TX_Word  in  WORD_BITS  reply word.
- i_TX_DV  in  1  one-cycle strobe that loads i_TX_Word.
- o_RX_Word  out  WORD_BITS  last complete received word.
- o_RX_DV  out  1  one-cycle strobe: o_RX_Word updated.
- o_Frame_Err  out  1  one-cycle strobe: short or over-length frame.
- o_Busy  out  1  high while a frame is in progress.

Function
REQ-003 i_SPI_Clk, i_SPI_MOSI and i_SPI_CS_n SHALL each pass through a SYNC_STAGES-flop synchronizer plus one history flop before any use; edges SHALL be detected from the synchronized signal and its history flop only.
REQ-004 The state machine SHALL have two states, IDLE and SHIFT:
- IDLE -> SHIFT on a synchronized CS_n falling edge.
- SHIFT -> IDLE on a synchronized CS_n rising edge.
REQ-005 On entering SHIFT:
- the bit counter SHALL clear to 0;
- the TX shift register SHALL load the TX holding register;
- o_SPI_MISO SHALL present its MSB within the same cycle.
REQ-006 In SHIFT, each synchronized SCK rising edge SHALL shift the synchronized MOSI into the RX shift register LSB and increment the bit counter. The counter SHALL saturate at WORD_BITS+1.
REQ-007 In SHIFT, each synchronized SCK falling edge SHALL shift the TX register left and present the next bit on o_SPI_MISO; after WORD_BITS bits, o_SPI_MISO SHALL be 0.
REQ-008 SCK edges SHALL be ignored in IDLE, and in the cycle a CS_n edge is detected.
REQ-009 On the CS_n rising edge, exactly one of the following SHALL occur:
- count == WORD_BITS: o_RX_Word <= RX shift register; o_RX_DV pulses high for one cycle.
- count == 0: no strobe.
- any other count: o_Frame_Err pulses high for one cycle; o_RX_Word holds its value.
REQ-010 Latency: o_RX_DV/o_Frame_Err SHALL assert exactly SYNC_STAGES+1 i_Clk cycles after the first i_Clk edge that samples raw i_SPI_CS_n high.
REQ-011 i_TX_DV SHALL load the holding register in any state. A load during SHIFT SHALL affect only the next frame. If i_TX_DV coincides with a CS_n falling edge, the new i_TX_Word SHALL be used for that frame.
REQ-012 With no i_TX_DV since the previous frame, the holding register SHALL retain its value, so the last word is re-sent.
REQ-013 o_Busy SHALL equal (state == SHIFT).
REQ-014 o_SPI_MISO SHALL be 0 in IDLE.
REQ-015 Correct operation SHALL be required only when SCK high and low times are each >= SYNC_STAGES+2 i_Clk periods and CS_n setup/hold around SCK is >= the same.

Reset
REQ-016 While i_Rst is high at an i_Clk edge, the block SHALL:
- set state to IDLE;
- clear the bit counter, both shift registers, the holding register and o_RX_Word to 0;
- drive o_RX_DV, o_Frame_Err, o_Busy and o_SPI_MISO to 0;
- preset synchronizer and history flops to idle levels (CS_n=1, SCK=0).
REQ-017 Reset asserted mid-frame SHALL abort the frame with no strobe. If CS_n is still low after reset releases, the block SHALL stay IDLE until the next CS_n falling edge.

Structure
REQ-018 Shared package contents SHALL be:
- the state enumeration (IDLE, SHIFT);
- the SPI mode constant (mode 0);
- the default WORD_BITS (16).
REQ-019 The synchronizer plus edge detector SHALL be one sub-module, spi_sync_edge, instantiated three times. It outputs the synchronized level, a rise strobe and a fall strobe.

Verification
REQ-020 The bench SHALL drive the block from the team's SPI master at CLKS_PER_HALF_BIT=4 and SHALL cover:
- Two-byte frame 0xA5, 0x3C under one CS_n -> o_RX_Word=0xA53C, one o_RX_DV pulse at REQ-010 latency, o_Frame_Err=0.
- i_TX_Word=0x8001 loaded with i_TX_DV before CS_n falls, during a 16-bit frame -> master receives 0x8001; o_SPI_MISO=0 after CS_n rises.
- Frame of 8 bits, then CS_n high -> one o_Frame_Err pulse; o_RX_Word unchanged from the prior 0xA53C.
- Frame of 17 bits -> o_Frame_Err pulse, no o_RX_DV.
- i_Rst pulsed after 9 bits, with CS_n held low through the end of the frame -> no strobes. The next clean 16-bit frame 0x1234 -> o_RX_DV, o_RX_Word=0x1234.
- Back-to-back frames 0xFFFF then 0x0000 with CS_n high for 4 i_Clk cycles; i_TX_DV 0x5555 asserted during the first frame -> two o_RX_DV pulses with the correct words; second MISO frame = 0x5555.

Source files
------------

// File: rtl/spi_slave_word_rx_pkg.sv
// Shared types and constants for the SPI word receiver.
package spi_slave_word_rx_pkg;

  typedef enum logic {
    StIdle,
    StShift
  } spi_state_e;

  localparam int unsigned SPI_MODE          = 0;
  localparam int unsigned DEFAULT_WORD_BITS = 16;

endpackage

// File: rtl/spi_slave_word_rx_if.sv
// Word-side handshake between the SPI receiver and its host logic.
interface spi_slave_word_rx_if
  import spi_slave_word_rx_pkg::*;
#(
  parameter int unsigned WORD_BITS = DEFAULT_WORD_BITS
);
  logic [WORD_BITS-1:0] i_TX_Word;
  logic                 i_TX_DV;
  logic [WORD_BITS-1:0] o_RX_Word;
  logic                 o_RX_DV;
  logic                 o_Frame_Err;
  logic                 o_Busy;

  modport slave (
    input  i_TX_Word, i_TX_DV,
    output o_RX_Word, o_RX_DV, o_Frame_Err, o_Busy
  );

  modport master (
    output i_TX_Word, i_TX_DV,
    input  o_RX_Word, o_RX_DV, o_Frame_Err, o_Busy
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with history flop and registered rise/fall strobes.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_LEVEL  = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Async,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync_out;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_sync <= {SYNC_STAGES{IDLE_LEVEL}};
      r_hist <= IDLE_LEVEL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync[0] <= i_Async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_hist <= w_sync_out;
      r_rise <= w_sync_out & ~r_hist;
      r_fall <= ~w_sync_out & r_hist;
    end
  end

  // Level is taken from the history flop so it lines up with the registered strobes.
  assign o_Level = r_hist;
  assign o_Rise  = r_rise;
  assign o_Fall  = r_fall;
endmodule

// File: rtl/spi_slave_word_rx.sv
// SPI mode-0 slave: receives WORD_BITS-bit frames, replies from a holding register.
module spi_slave_word_rx
  import spi_slave_word_rx_pkg::*;
#(
  parameter int unsigned WORD_BITS   = DEFAULT_WORD_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_SPI_Clk,
  input  logic                    i_SPI_MOSI,
  input  logic                    i_SPI_CS_n,
  output logic                    o_SPI_MISO,
  spi_slave_word_rx_if.slave      word_if
);
  localparam int unsigned CntW     = $clog2(WORD_BITS + 2);
  localparam int unsigned Settle   = SYNC_STAGES + 2;
  localparam int unsigned SetW     = $clog2(Settle + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(WORD_BITS);
  localparam logic [CntW-1:0] CntMax  = CntW'(WORD_BITS + 1);
  localparam logic [SetW-1:0] SetMax  = SetW'(Settle);

  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_mosi_level, w_mosi_rise, w_mosi_fall;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sck (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SPI_Clk),
    .o_Level(w_sck_level), .o_Rise(w_sck_rise), .o_Fall(w_sck_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_mosi (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SPI_MOSI),
    .o_Level(w_mosi_level), .o_Rise(w_mosi_rise), .o_Fall(w_mosi_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SPI_CS_n),
    .o_Level(w_cs_level), .o_Rise(w_cs_rise), .o_Fall(w_cs_fall)
  );

  assign w_unused = ^{w_sck_level, w_mosi_rise, w_mosi_fall};

  spi_state_e           r_state, w_state_next;
  logic [CntW-1:0]      r_cnt, w_cnt_next;
  logic [WORD_BITS-1:0] r_rx_sr, w_rx_sr_next;
  logic [WORD_BITS-1:0] r_tx_sr, w_tx_sr_next;
  logic [WORD_BITS-1:0] r_tx_hold, w_tx_hold_next;
  logic [WORD_BITS-1:0] r_rx_word, w_rx_word_next;
  logic                 r_rx_dv, w_rx_dv_next;
  logic                 r_frame_err, w_frame_err_next;
  logic [SetW-1:0]      r_settle;
  logic                 r_armed;
  logic                 w_sck_en;

  // A CS_n fall is only trusted once the synchronizer has flushed its reset preset
  // and CS_n has really been seen high; this keeps a mid-frame reset from re-entering SHIFT.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      if (r_settle != SetMax) r_settle <= r_settle + SetW'(1);
      if (r_settle == SetMax && w_cs_level) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_rx_sr     <= '0;
      r_tx_sr     <= '0;
      r_tx_hold   <= '0;
      r_rx_word   <= '0;
      r_rx_dv     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_rx_sr     <= w_rx_sr_next;
      r_tx_sr     <= w_tx_sr_next;
      r_tx_hold   <= w_tx_hold_next;
      r_rx_word   <= w_rx_word_next;
      r_rx_dv     <= w_rx_dv_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  assign w_sck_en = (r_state == StShift) && !w_cs_fall && !w_cs_rise;

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_rx_sr_next     = r_rx_sr;
    w_tx_sr_next     = r_tx_sr;
    w_tx_hold_next   = word_if.i_TX_DV ? word_if.i_TX_Word : r_tx_hold;
    w_rx_word_next   = r_rx_word;
    w_rx_dv_next     = 1'b0;
    w_frame_err_next = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_cs_fall && r_armed) begin
          w_state_next = StShift;
          w_cnt_next   = '0;
          w_tx_sr_next = word_if.i_TX_DV ? word_if.i_TX_Word : r_tx_hold;
        end
      end
      StShift: begin
        if (w_cs_rise) begin
          w_state_next = StIdle;
          if (r_cnt == CntFull) begin
            w_rx_word_next = r_rx_sr;
            w_rx_dv_next   = 1'b1;
          end else if (r_cnt != '0) begin
            w_frame_err_next = 1'b1;
          end
        end else if (w_sck_en) begin
          if (w_sck_rise) begin
            w_rx_sr_next = {r_rx_sr[WORD_BITS-2:0], w_mosi_level};
            if (r_cnt != CntMax) w_cnt_next = r_cnt + CntW'(1);
          end
          if (w_sck_fall) w_tx_sr_next = {r_tx_sr[WORD_BITS-2:0], 1'b0};
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_SPI_MISO          = (r_state == StShift) & r_tx_sr[WORD_BITS-1];
  assign word_if.o_RX_Word   = r_rx_word;
  assign word_if.o_RX_DV     = r_rx_dv;
  assign word_if.o_Frame_Err = r_frame_err;
  assign word_if.o_Busy      = (r_state == StShift);
endmodule
